// File: rtl/branch_resolve_bht_pkg.sv
// branch_resolve_bht_pkg
//   Shared constants for branch resolution and the branch history table:
//   branch Type codes, the Type field width and default table geometry.
//   Optional feature macro used by branch_resolve_bht: BHT_STATS_EN
//   (adds stat_branches / stat_mispred counters).
package branch_resolve_bht_pkg;

  localparam int TYPE_W    = 4;
  localparam int DEF_IDX_W = 6;
  localparam int DEF_CNT_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BGEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLEZ = 4'd5,
    BR_BLTZ = 4'd6
  } br_type_e;

  // Types that carry a real condition and therefore train the BHT.
  function automatic logic is_cond_type(input logic [TYPE_W-1:0] t);
    return (t >= 4'd1) && (t <= 4'd6);
  endfunction

endpackage

// File: rtl/branch_resolve_bht_cond_eval.sv
// branch_cond_eval
//   Purely combinational branch condition evaluator, usable by any stage
//   that resolves branches.
//   Ports:
//     A, B   in  DATA_W  operands (signed compares on A use full width)
//     Type   in  4       branch type code (unknown codes resolve not-taken)
//     taken  out 1       condition result
module branch_cond_eval
  import branch_resolve_bht_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [TYPE_W-1:0] Type,
  output logic              taken
);

  logic neg, zero;

  // Sign bit and zero test cover every signed compare against 0.
  assign neg  = A[DATA_W-1];
  assign zero = (A == '0);

  always_comb begin
    taken = 1'b0;
    case (Type)
      BR_BEQ:  taken = (A == B);
      BR_BNE:  taken = (A != B);
      BR_BGEZ: taken = !neg;
      BR_BGTZ: taken = !neg && !zero;
      BR_BLEZ: taken = neg || zero;
      BR_BLTZ: taken = neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
//   Resolves the D-stage branch condition and predicts the F-stage branch
//   direction from a PC-indexed table of saturating counters.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     lookup_pc           F-stage PC;  pred_taken = MSB of its counter
//     resolve_valid/_pc   D-stage branch present / its PC
//     A, B, Type          operands and branch type for resolution
//     pred_in             prediction that travelled with the D instruction
//     stall               D stalled: no table update this cycle
//     taken, mispredict   combinational resolution outputs
//   Macro BHT_STATS_EN adds stat_branches / stat_mispred (32-bit, wrapping).
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CNT_INIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       lookup_pc,
  output logic              pred_taken,
  input  logic              resolve_valid,
  input  logic [31:0]       resolve_pc,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [TYPE_W-1:0] Type,
  input  logic              pred_in,
  input  logic              stall,
  output logic              taken,
  output logic              mispredict
`ifdef BHT_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_RST = cnt_t'(CNT_INIT);

  cnt_t             cnt_q [DEPTH];
  cnt_t             cnt_d [DEPTH];
  logic [IDX_W-1:0] lk_idx, rs_idx;
  logic             cond_taken, upd;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign rs_idx = resolve_pc[IDX_W+1:2];

  // Word-aligned index; the remaining PC bits intentionally alias.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            resolve_pc[31:IDX_W+2], resolve_pc[1:0]};

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .A     (A),
    .B     (B),
    .Type  (Type),
    .taken (cond_taken)
  );

  assign taken      = resolve_valid & cond_taken;
  assign mispredict = resolve_valid & (taken != pred_in);

  // Stalled cycles never train, so a re-presented branch updates once.
  assign upd = resolve_valid & ~stall & is_cond_type(Type);

  // No bypass: same-cycle lookup sees the old counter value.
  assign pred_taken = cnt_q[lk_idx][CNT_W-1];

  always_comb begin
    cnt_d = cnt_q;
    if (upd) begin
      if (taken && (cnt_q[rs_idx] != CNT_MAX))
        cnt_d[rs_idx] = cnt_q[rs_idx] + cnt_t'(1);
      else if (!taken && (cnt_q[rs_idx] != '0))
        cnt_d[rs_idx] = cnt_q[rs_idx] - cnt_t'(1);
    end
  end

  // Reset wins over a coincident update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q + {31'd0, upd};
    mp_cnt_d = mp_cnt_q + {31'd0, upd & mispredict};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign stat_branches = br_cnt_q;
  assign stat_mispred  = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht (IDX_W=6, CNT_W=2, CNT_INIT=1).
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_branch_resolve_bht;
  import branch_resolve_bht_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc, resolve_pc, A, B;
  logic        pred_taken, resolve_valid, pred_in, stall, taken, mispredict;
  logic [3:0]  Type;
`ifdef BHT_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_bht #(.DATA_W(32), .IDX_W(6), .CNT_W(2), .CNT_INIT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (lookup_pc),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_pc    (resolve_pc),
    .A             (A),
    .B             (B),
    .Type          (Type),
    .pred_in       (pred_in),
    .stall         (stall),
    .taken         (taken),
    .mispredict    (mispredict)
`ifdef BHT_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] t,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic p, input logic s);
    resolve_valid = 1'b1; resolve_pc = pc; Type = t;
    A = a; B = b; pred_in = p; stall = s;
  endtask

  task automatic idle();
    resolve_valid = 1'b0; Type = 4'd0; stall = 1'b0; pred_in = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; lookup_pc = 32'h3000; A = '0; B = '0; resolve_pc = '0;
    tick(); tick();
    reset = 1'b0; #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_pred got=%b exp=0", pred_taken);
    end
    vectors++;
    if ({taken, mispredict} !== 2'b00) begin
      miscompares++; $display("FAIL reset_idle_outs got=%b exp=00", {taken, mispredict});
    end
  endtask

  task automatic test_beq();
    lookup_pc = 32'h3000;
    drive(32'h3000, BR_BEQ, 32'd5, 32'd5, 1'b0, 1'b0); #1;
    vectors++;
    if ({taken, mispredict, pred_taken} !== 3'b110) begin
      miscompares++; $display("FAIL beq_resolve got=%b exp=110", {taken, mispredict, pred_taken});
    end
    tick(); idle(); #1;
    vectors++;
    if ({pred_taken, taken, mispredict} !== 3'b100) begin
      miscompares++; $display("FAIL beq_trained got=%b exp=100", {pred_taken, taken, mispredict});
    end
  endtask

  // 1 ->(T)2,3,3,3 ->(N)2,1,0,0 ; pred = MSB
  task automatic test_saturate();
    lookup_pc = 32'h3004;
    for (int i = 0; i < 8; i++) begin
      logic t, exp_p;
      t = (i < 4);
      exp_p = (i < 5);
      drive(32'h3004, BR_BNE, 32'd1, t ? 32'd2 : 32'd1, 1'b1, 1'b0);
      tick();
      vectors++;
      if (pred_taken !== exp_p) begin
        miscompares++; $display("FAIL sat_step%0d got=%b exp=%b", i, pred_taken, exp_p);
      end
    end
    idle();
  endtask

  task automatic test_signed();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [3:0]  vt [12];
    logic        ve [12];
    va = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
           32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h7fffffff, 32'h5, 32'h5};
    vb = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
           32'h0, 32'h5, 32'h6};
    vt = '{4'd6, 4'd5, 4'd3, 4'd4, 4'd3, 4'd5, 4'd4, 4'd4, 4'd6, 4'd3, 4'd9, 4'd1};
    ve = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(32'h3030, vt[i], va[i], vb[i], 1'b1, 1'b1); #1;
      vectors++;
      if (taken !== ve[i]) begin
        miscompares++; $display("FAIL signed_taken%0d got=%b exp=%b", i, taken, ve[i]);
      end
      vectors++;
      if (mispredict !== !ve[i]) begin
        miscompares++; $display("FAIL signed_mispred%0d got=%b exp=%b", i, mispredict, !ve[i]);
      end
    end
    // Unknown / NONE types leave the counter alone.
    lookup_pc = 32'h3010;
    drive(32'h3010, BR_BEQ, 32'd2, 32'd2, 1'b0, 1'b0); tick();
    drive(32'h3010, 4'd9, 32'd5, 32'd5, 1'b1, 1'b0); #1;
    vectors++;
    if ({taken, mispredict} !== 2'b01) begin
      miscompares++; $display("FAIL type9_outs got=%b exp=01", {taken, mispredict});
    end
    tick();
    drive(32'h3010, BR_NONE, 32'd5, 32'd5, 1'b0, 1'b0); tick(); idle(); #1;
    vectors++;
    if (pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL type9_noupd got=%b exp=1", pred_taken);
    end
  endtask

  task automatic test_stall();
    lookup_pc = 32'h3008;
    drive(32'h3008, BR_BEQ, 32'd7, 32'd7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pred_taken !== 1'b0) begin
        miscompares++; $display("FAIL stall_hold%0d got=%b exp=0", i, pred_taken);
      end
    end
    stall = 1'b0; tick();
    vectors++;
    if (pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL stall_release got=%b exp=1", pred_taken);
    end
    // Counter must be 2, so one not-taken drops the MSB.
    drive(32'h3008, BR_BEQ, 32'd7, 32'd8, 1'b1, 1'b0); tick(); idle(); #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL stall_once got=%b exp=0", pred_taken);
    end
  endtask

  task automatic test_hazard();
    lookup_pc = 32'h300C;
    drive(32'h300C, BR_BEQ, 32'd1, 32'd1, 1'b0, 1'b0); #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL hazard_same_cycle got=%b exp=0", pred_taken);
    end
    tick(); idle(); #1;
    vectors++;
    if (pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL hazard_next got=%b exp=1", pred_taken);
    end
    lookup_pc = 32'h310C; #1;
    vectors++;
    if (pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL alias_read got=%b exp=1", pred_taken);
    end
    drive(32'h310C, BR_BEQ, 32'd1, 32'd2, 1'b1, 1'b0); tick(); idle();
    lookup_pc = 32'h300C; #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL alias_write got=%b exp=0", pred_taken);
    end
    drive(32'h300C, BR_BEQ, 32'd1, 32'd1, 1'b0, 1'b0); tick(); idle();
  endtask

  task automatic test_reset_drop();
    lookup_pc = 32'h300C;
    drive(32'h300C, BR_BEQ, 32'd1, 32'd1, 1'b0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0; idle(); #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_drop got=%b exp=0", pred_taken);
    end
    lookup_pc = 32'h3000; #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_reinit got=%b exp=0", pred_taken);
    end
  endtask

`ifdef BHT_STATS_EN
  task automatic test_stats();
    vectors++;
    if ({stat_branches, stat_mispred} !== 64'd0) begin
      miscompares++; $display("FAIL stats_init got=%0d/%0d exp=0/0", stat_branches, stat_mispred);
    end
    for (int i = 0; i < 10; i++) begin
      drive(32'h3020, BR_BEQ, 32'd3, 32'd3, (i >= 3), 1'b0); tick();
      if (i == 4) begin
        // Non-qualified cycles: stalled, unknown type, idle.
        drive(32'h3020, BR_BEQ, 32'd3, 32'd3, 1'b0, 1'b1); tick();
        drive(32'h3020, 4'd9, 32'd3, 32'd3, 1'b1, 1'b0); tick();
        idle(); tick();
      end
    end
    idle(); #1;
    vectors++;
    if (stat_branches !== 32'd10) begin
      miscompares++; $display("FAIL stats_branches got=%0d exp=10", stat_branches);
    end
    vectors++;
    if (stat_mispred !== 32'd3) begin
      miscompares++; $display("FAIL stats_mispred got=%0d exp=3", stat_mispred);
    end
    drive(32'h3020, BR_BEQ, 32'd3, 32'd3, 1'b0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0; idle(); #1;
    vectors++;
    if ({stat_branches, stat_mispred} !== 64'd0) begin
      miscompares++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", stat_branches, stat_mispred);
    end
    tick();
    vectors++;
    if ({stat_branches, stat_mispred} !== 64'd0) begin
      miscompares++; $display("FAIL stats_reset_drop got=%0d/%0d exp=0/0", stat_branches, stat_mispred);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_beq();
    test_saturate();
    test_signed();
    test_stall();
    test_hazard();
    test_reset_drop();
`ifdef BHT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
